// File: rtl/triangle_scheduler.sv
// rtl/triangle_scheduler.sv - triangle FIFO and issue scheduler feeding the Rasteriser
// Queues vertex sets, issues one at a time, and tracks per-frame completion.
module triangle_scheduler #(
    parameter int DEPTH   = 4,
    parameter int COORD_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tri_valid,
    output logic                     tri_ready,
    input  logic [6*COORD_W-1:0]     tri_coords,
    input  logic                     tri_last,
    output logic                     opcode_received,
    output logic [COORD_W-1:0]       x1,
    output logic [COORD_W-1:0]       y1,
    output logic [COORD_W-1:0]       x2,
    output logic [COORD_W-1:0]       y2,
    output logic [COORD_W-1:0]       x3,
    output logic [COORD_W-1:0]       y3,
    input  logic                     next_triangle,
    output logic                     frame_ready,
    output logic                     busy,
    output logic [7:0]               tri_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = 6 * COORD_W + 1;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT       = 2'd2,
        S_FRAME_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [EW-1:0]         r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW:0]           r_level;
    logic [6*COORD_W-1:0]  r_coords;
    logic                  r_cur_last;
    logic [7:0]            r_tri_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    // Full is judged on the registered level only, so a same-cycle pop never reopens the input.
    assign w_full  = (r_level == (PW+1)'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = tri_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {tri_coords, tri_last};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:       if (!w_empty) w_next_state = S_ISSUE;
            S_ISSUE:      w_next_state = S_WAIT;
            S_WAIT:       if (next_triangle) w_next_state = r_cur_last ? S_FRAME_DONE : S_IDLE;
            S_FRAME_DONE: w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        opcode_received = 1'b0;
        frame_ready     = 1'b0;
        busy            = 1'b1;
        case (r_state)
            S_IDLE:       busy = 1'b0;
            S_ISSUE:      opcode_received = 1'b1;
            S_FRAME_DONE: frame_ready = 1'b1;
            default:      busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_coords    <= '0;
            r_cur_last  <= 1'b0;
            r_tri_count <= '0;
        end else begin
            if (w_pop) begin
                {r_coords, r_cur_last} <= r_mem[r_rd_ptr];
            end
            if (r_state == S_WAIT && next_triangle && r_tri_count != 8'hFF) begin
                r_tri_count <= r_tri_count + 8'd1;
            end else if (r_state == S_FRAME_DONE) begin
                r_tri_count <= '0;
            end
        end
    end

    assign {x1, y1, x2, y2, x3, y3} = r_coords;
    assign tri_ready  = !w_full;
    assign tri_count  = r_tri_count;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_triangle_scheduler.sv
// tb/tb_triangle_scheduler.sv - directed self-checking bench for triangle_scheduler
module tb_triangle_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tri_valid = 1'b0;
    logic        tri_ready;
    logic [95:0] tri_coords = '0;
    logic        tri_last = 1'b0;
    logic        opcode_received;
    logic [15:0] x1, y1, x2, y2, x3, y3;
    logic        next_triangle = 1'b0;
    logic        frame_ready;
    logic        busy;
    logic [7:0]  tri_count;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    int op_cnt = 0;
    int fr_cnt = 0;
    logic [7:0]  fr_tc;
    logic [95:0] op_log [256];

    triangle_scheduler #(.DEPTH(4), .COORD_W(16)) dut (
        .clk(clk), .reset(reset),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_coords(tri_coords), .tri_last(tri_last),
        .opcode_received(opcode_received),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
        .next_triangle(next_triangle), .frame_ready(frame_ready),
        .busy(busy), .tri_count(tri_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (opcode_received) begin
            op_log[op_cnt[7:0]] = {x1, y1, x2, y2, x3, y3};
            op_cnt++;
        end
        if (frame_ready) begin
            fr_cnt++;
            fr_tc = tri_count;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [95:0] mk(input int id);
        logic [15:0] b;
        b = 16'(id * 8);
        return {b + 16'd1, b + 16'd2, b + 16'd3, b + 16'd4, b + 16'd5, b + 16'd6};
    endfunction

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        tri_valid = 1'b0;
        next_triangle = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_tri(input int id, input logic last, output bit ok);
        int n;
        @(negedge clk);
        tri_coords = mk(id);
        tri_last = last;
        tri_valid = 1'b1;
        n = 0;
        while (!tri_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = tri_ready;
        @(posedge clk);
        #1 tri_valid = 1'b0;
    endtask

    task automatic complete_one(input int target, input int gap, output bit ok);
        int n;
        n = 0;
        while (op_cnt < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (op_cnt >= target);
        repeat (gap) @(negedge clk);
        next_triangle = 1'b1;
        @(negedge clk);
        next_triangle = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
        checks++; if (tri_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", tri_ready); end
        checks++; if ({busy, opcode_received, frame_ready} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {busy, opcode_received, frame_ready}); end
        checks++; if (tri_count !== 8'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", tri_count); end
        checks++; if ({x1, y1, x2, y2, x3, y3} !== 96'd0) begin errors++; $display("FAIL rst_coords got %h exp 0", {x1, y1, x2, y2, x3, y3}); end
        reset = 1'b0;
    endtask

    task automatic test_single;
        bit ok, ok2;
        int ob, fb;
        do_reset();
        ob = op_cnt; fb = fr_cnt;
        push_tri(0, 1'b1, ok);
        @(negedge clk);
        checks++; if (fifo_level !== 3'd1 || busy !== 1'b0) begin errors++; $display("FAIL single_queued level %0d busy %b exp 1 0", fifo_level, busy); end
        @(negedge clk);
        checks++; if (opcode_received !== 1'b1) begin errors++; $display("FAIL single_latency opcode got %b exp 1", opcode_received); end
        checks++; if ({x1, y1, x2, y2, x3, y3} !== mk(0)) begin errors++; $display("FAIL single_coords got %h exp %h", {x1, y1, x2, y2, x3, y3}, mk(0)); end
        complete_one(ob + 1, 5, ok2);
        checks++; if (!(ok && ok2)) begin errors++; $display("FAIL single_timeout got %b%b exp 11", ok, ok2); end
        checks++; if (frame_ready !== 1'b1 || tri_count !== 8'd1) begin errors++; $display("FAIL single_frame fr %b cnt %0d exp 1 1", frame_ready, tri_count); end
        @(negedge clk);
        checks++; if (frame_ready !== 1'b0 || tri_count !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL single_after fr %b cnt %0d busy %b exp 0 0 0", frame_ready, tri_count, busy); end
        checks++; if (op_cnt - ob !== 1 || fr_cnt - fb !== 1) begin errors++; $display("FAIL single_pulses op %0d fr %0d exp 1 1", op_cnt - ob, fr_cnt - fb); end
    endtask

    task automatic test_fifo_full;
        bit ok, okall;
        int ob, fb;
        do_reset();
        ob = op_cnt; fb = fr_cnt; okall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_tri(10 + i, 1'b0, ok);
            okall &= ok;
        end
        @(negedge clk);
        checks++; if (fifo_level !== 3'd4 || tri_ready !== 1'b0) begin errors++; $display("FAIL full_level level %0d ready %b exp 4 0", fifo_level, tri_ready); end
        checks++; if (op_cnt - ob !== 1 || busy !== 1'b1) begin errors++; $display("FAIL full_first_issued op %0d busy %b exp 1 1", op_cnt - ob, busy); end
        tri_coords = mk(15);
        tri_last = 1'b0;
        tri_valid = 1'b1;
        @(negedge clk);
        checks++; if (fifo_level !== 3'd4 || tri_ready !== 1'b0) begin errors++; $display("FAIL full_stall level %0d ready %b exp 4 0", fifo_level, tri_ready); end
        fork
            push_tri(15, 1'b0, ok);
            begin
                next_triangle = 1'b1;
                @(negedge clk);
                next_triangle = 1'b0;
            end
        join
        okall &= ok;
        for (int i = 2; i <= 6; i++) begin
            complete_one(ob + i, 1, ok);
            okall &= ok;
        end
        checks++; if (!okall) begin errors++; $display("FAIL full_timeout got 0 exp 1"); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (op_log[(ob + i) % 256] !== mk(10 + i)) begin errors++; $display("FAIL full_order idx %0d got %h exp %h", i, op_log[(ob + i) % 256], mk(10 + i)); end
        end
        checks++; if (tri_count !== 8'd6 || fifo_level !== 3'd0 || fr_cnt !== fb) begin errors++; $display("FAIL full_end cnt %0d level %0d frames %0d exp 6 0 %0d", tri_count, fifo_level, fr_cnt, fb); end
    endtask

    task automatic test_frame3;
        bit ok, okall;
        int ob, fb;
        do_reset();
        ob = op_cnt; fb = fr_cnt; okall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_tri(20 + i, (i == 2), ok);
            okall &= ok;
        end
        for (int i = 1; i <= 3; i++) begin
            complete_one(ob + i, 1, ok);
            okall &= ok;
            if (i < 3) begin
                checks++; if (fr_cnt !== fb) begin errors++; $display("FAIL f3_early_frame after %0d got %0d exp %0d", i, fr_cnt, fb); end
            end
        end
        checks++; if (!okall) begin errors++; $display("FAIL f3_timeout got 0 exp 1"); end
        checks++; if (frame_ready !== 1'b1 || tri_count !== 8'd3) begin errors++; $display("FAIL f3_frame fr %b cnt %0d exp 1 3", frame_ready, tri_count); end
        repeat (3) @(negedge clk);
        checks++; if (fr_cnt - fb !== 1 || fr_tc !== 8'd3) begin errors++; $display("FAIL f3_once frames %0d cnt %0d exp 1 3", fr_cnt - fb, fr_tc); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (op_log[(ob + i) % 256] !== mk(20 + i)) begin errors++; $display("FAIL f3_order idx %0d got %h exp %h", i, op_log[(ob + i) % 256], mk(20 + i)); end
        end
    endtask

    task automatic test_spurious;
        bit ok;
        int ob;
        do_reset();
        ob = op_cnt;
        next_triangle = 1'b1;
        @(negedge clk);
        next_triangle = 1'b0;
        checks++; if (tri_count !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL spur_idle cnt %0d busy %b exp 0 0", tri_count, busy); end
        push_tri(30, 1'b0, ok);
        @(negedge clk);
        @(negedge clk);
        checks++; if (opcode_received !== 1'b1 || !ok) begin errors++; $display("FAIL spur_issue opcode %b exp 1", opcode_received); end
        next_triangle = 1'b1;
        @(negedge clk);
        next_triangle = 1'b0;
        checks++; if (busy !== 1'b1 || tri_count !== 8'd0 || opcode_received !== 1'b0) begin errors++; $display("FAIL spur_wait busy %b cnt %0d op %b exp 1 0 0", busy, tri_count, opcode_received); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1 || tri_count !== 8'd0 || op_cnt - ob !== 1) begin errors++; $display("FAIL spur_hold busy %b cnt %0d ops %0d exp 1 0 1", busy, tri_count, op_cnt - ob); end
        next_triangle = 1'b1;
        @(negedge clk);
        next_triangle = 1'b0;
        checks++; if (busy !== 1'b0 || tri_count !== 8'd1 || frame_ready !== 1'b0) begin errors++; $display("FAIL spur_real busy %b cnt %0d fr %b exp 0 1 0", busy, tri_count, frame_ready); end
    endtask

    task automatic test_reset_mid;
        bit ok, okall;
        int ob, fb;
        do_reset();
        okall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_tri(40 + i, 1'b1, ok);
            okall &= ok;
        end
        @(negedge clk);
        checks++; if (fifo_level !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL rmid_pre level %0d busy %b exp 2 1", fifo_level, busy); end
        ob = op_cnt; fb = fr_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (fifo_level !== 3'd0 || tri_count !== 8'd0 || tri_ready !== 1'b1) begin errors++; $display("FAIL rmid_fifo level %0d cnt %0d ready %b exp 0 0 1", fifo_level, tri_count, tri_ready); end
        checks++; if ({x1, y1, x2, y2, x3, y3} !== 96'd0 || {busy, opcode_received, frame_ready} !== 3'b000) begin errors++; $display("FAIL rmid_outs coords %h flags %b exp 0 000", {x1, y1, x2, y2, x3, y3}, {busy, opcode_received, frame_ready}); end
        repeat (3) @(negedge clk);
        checks++; if (op_cnt !== ob || fr_cnt !== fb) begin errors++; $display("FAIL rmid_quiet ops %0d frames %0d exp %0d %0d", op_cnt, fr_cnt, ob, fb); end
        push_tri(45, 1'b1, ok);
        okall &= ok;
        complete_one(ob + 1, 1, ok);
        okall &= ok;
        checks++; if (!okall || frame_ready !== 1'b1 || tri_count !== 8'd1) begin errors++; $display("FAIL rmid_after ok %b fr %b cnt %0d exp 1 1 1", okall, frame_ready, tri_count); end
        checks++; if (op_log[ob % 256] !== mk(45)) begin errors++; $display("FAIL rmid_coords got %h exp %h", op_log[ob % 256], mk(45)); end
    endtask

    task automatic test_wrap;
        bit ok, okall;
        int ob, fb;
        do_reset();
        ob = op_cnt; fb = fr_cnt; okall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_tri(50 + i, (i == 9), ok);
            okall &= ok;
            complete_one(ob + i + 1, 1, ok);
            okall &= ok;
        end
        checks++; if (!okall) begin errors++; $display("FAIL wrap_timeout got 0 exp 1"); end
        checks++; if (frame_ready !== 1'b1 || tri_count !== 8'd10) begin errors++; $display("FAIL wrap_frame fr %b cnt %0d exp 1 10", frame_ready, tri_count); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (op_log[(ob + i) % 256] !== mk(50 + i)) begin errors++; $display("FAIL wrap_order idx %0d got %h exp %h", i, op_log[(ob + i) % 256], mk(50 + i)); end
        end
        @(negedge clk);
        checks++; if (fr_cnt - fb !== 1 || fifo_level !== 3'd0 || tri_count !== 8'd0) begin errors++; $display("FAIL wrap_end frames %0d level %0d cnt %0d exp 1 0 0", fr_cnt - fb, fifo_level, tri_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fifo_full();
        test_frame3();
        test_spurious();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
